spi_master64: RTL and testbench

SPI_MASTER64 -- requirements
Module: spi_master64

---
 rtl/des_spi_pkg.sv | 15 +
 rtl/spi_phase_timer.sv | 26 ++
 rtl/spi_master64.sv | 139 +++++++++++++
 tb/tb_spi_master64.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_spi_pkg.sv
// Shared constants and FSM encoding for the 64-bit SPI master.
package des_spi_pkg;
  localparam int unsigned WORD_W    = 64;
  localparam int unsigned BIT_CNT_W = 6;
  localparam int unsigned TIMER_W   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_e;
endpackage

// File: rtl/spi_phase_timer.sv
// Phase/delay down-counter: loaded on every state change, expires at zero.
module spi_phase_timer
  import des_spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire_c
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  assign expire_c = (cnt == '0);

endmodule

// File: rtl/spi_master64.sv
// 64-bit SPI master, mode 0, with programmable CS setup/hold/gap timing.
module spi_master64
  import des_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] tx_text,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rx_text,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  spi_state_e           state;
  logic [WORD_W-1:0]    tx_sr;
  logic [WORD_W-1:0]    rx_sr;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 last_bit_c;
  logic                 tmr_load_c;
  logic [TIMER_W-1:0]   tmr_val_c;
  logic                 tmr_expire_c;

  assign last_bit_c = (bit_cnt == '1);

  spi_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .expire_c (tmr_expire_c)
  );

  // Timer reload on each transition; GAP counts the done cycle plus CS_GAP quiet cycles.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    case (state)
      IDLE: begin
        tmr_load_c = start;
        tmr_val_c  = TIMER_W'(CS_SETUP - 1);
      end
      SETUP, LOW: begin
        tmr_load_c = tmr_expire_c;
        tmr_val_c  = TIMER_W'(CLK_DIV - 1);
      end
      HIGH: begin
        tmr_load_c = tmr_expire_c;
        tmr_val_c  = last_bit_c ? TIMER_W'(CS_HOLD - 1) : TIMER_W'(CLK_DIV - 1);
      end
      HOLD: begin
        tmr_load_c = tmr_expire_c;
        tmr_val_c  = TIMER_W'(CS_GAP);
      end
      default: begin
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
      end
    endcase
  end

  // Transfer FSM with registered SPI pins and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_text <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            mosi    <= tx_text[WORD_W-1];
            tx_sr   <= {tx_text[WORD_W-2:0], 1'b0};
            bit_cnt <= '0;
          end
        end
        SETUP: begin
          if (tmr_expire_c) state <= LOW;
        end
        LOW: begin
          if (tmr_expire_c) begin
            state <= HIGH;
            sclk  <= 1'b1;
          end
        end
        HIGH: begin
          if (tmr_expire_c) begin
            sclk  <= 1'b0;
            rx_sr <= {rx_sr[WORD_W-2:0], miso};
            tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
            if (last_bit_c) begin
              state <= HOLD;
              mosi  <= 1'b0;
            end else begin
              state   <= LOW;
              mosi    <= tx_sr[WORD_W-1];
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (tmr_expire_c) begin
            state   <= GAP;
            cs_n    <= 1'b1;
            rx_text <= rx_sr;
            done    <= 1'b1;
          end
        end
        GAP: begin
          if (tmr_expire_c) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master64.sv
// Directed bench for spi_master64: loopback via a mode-0 slave model, timing, abort, fast params.
module tb_spi_master64;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] tx_text = '0;
  logic        busy, done, sclk, cs_n, mosi;
  logic [63:0] rx_text;
  logic        miso = 1'b0;

  logic        start_f = 1'b0;
  logic [63:0] tx_f = '0;
  logic        busy_f, done_f, sclk_f, cs_n_f, mosi_f;
  logic [63:0] rx_f;

  int checks = 0;
  int failures = 0;

  // Slave model state
  logic [63:0] slv_resp = '0;
  logic [63:0] slv_out = '0;
  logic [63:0] slv_in = '0;
  int          slv_rises = 0;

  always #5 clk = ~clk;

  spi_master64 dut (
    .clk(clk), .rst(rst), .start(start), .tx_text(tx_text), .busy(busy), .done(done),
    .rx_text(rx_text), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master64 #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut_fast (
    .clk(clk), .rst(rst), .start(start_f), .tx_text(tx_f), .busy(busy_f), .done(done_f),
    .rx_text(rx_f), .sclk(sclk_f), .cs_n(cs_n_f), .mosi(mosi_f), .miso(1'b1)
  );

  // Mode-0 slave: sample mosi on sclk rise, present next bit on sclk fall.
  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) slv_rises = 0;
    else begin
      slv_in = {slv_in[62:0], mosi};
      slv_rises = slv_rises + 1;
    end
  end

  always @(negedge cs_n or negedge sclk) begin
    if (!cs_n) begin
      if (slv_rises == 0) slv_out = slv_resp;
      else slv_out = {slv_out[62:0], 1'b0};
      miso = slv_out[63];
    end
  end

  // Runs one transfer on the default DUT starting in the current IDLE cycle.
  task automatic xfer(input logic [63:0] tx, input logic [63:0] resp, input bit poke,
                      input logic [63:0] poke_tx,
                      output logic first_cs, output logic first_busy, output logic first_mosi,
                      output int cs_low, output int rises, output int busy_cyc,
                      output int done_cnt, output logic [63:0] rx, output logic mosi_hold,
                      output bit finished);
    logic prev_sclk;
    cs_low = 0; rises = 0; busy_cyc = 0; done_cnt = 0; rx = '0; mosi_hold = 1'b0;
    finished = 1'b0; prev_sclk = 1'b0;
    slv_resp = resp;
    tx_text = tx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_cs = cs_n; first_busy = busy; first_mosi = mosi;
    for (int i = 0; i < 4000; i++) begin
      start = 1'b0;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      busy_cyc++;
      if (!cs_n) cs_low++;
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (rises == 64 && !sclk && !cs_n) mosi_hold = mosi_hold | mosi;
      if (done) begin
        done_cnt++;
        rx = rx_text;
      end
      if (poke && (i == 100 || done)) begin
        start = 1'b1;
        tx_text = poke_tx;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
      failures++;
      $display("FAIL reset_pins: cs_n=%b sclk=%b mosi=%b want 1 0 0", cs_n, sclk, mosi);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (rx_text !== 64'h0) begin
      failures++;
      $display("FAIL reset_rx: got %h want 0", rx_text);
    end
    checks++;
    if (cs_n_f !== 1'b1 || busy_f !== 1'b0) begin
      failures++;
      $display("FAIL reset_fast: cs_n=%b busy=%b want 1 0", cs_n_f, busy_f);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback;
    logic fc, fb, fm, mh; int csl, rs, bc, dc; logic [63:0] rx; bit fin;
    xfer(64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1'b0, 64'h0,
         fc, fb, fm, csl, rs, bc, dc, rx, mh, fin);
    checks++;
    if (!fin) begin failures++; $display("FAIL loop_timeout: busy never fell"); end
    checks++;
    if (fc !== 1'b0 || fb !== 1'b1 || fm !== 1'b0) begin
      failures++;
      $display("FAIL loop_first_cycle: cs_n=%b busy=%b mosi=%b want 0 1 0", fc, fb, fm);
    end
    checks++;
    if (slv_in !== 64'h0123456789ABCDEF) begin
      failures++; $display("FAIL loop_slave_rx: got %h want 0123456789abcdef", slv_in);
    end
    checks++;
    if (rx !== 64'h85E813540F0AB405 || rx_text !== 64'h85E813540F0AB405) begin
      failures++; $display("FAIL loop_rx_text: got %h/%h want 85e813540f0ab405", rx, rx_text);
    end
    checks++;
    if (dc != 1) begin failures++; $display("FAIL loop_done_count: got %0d want 1", dc); end
    checks++;
    if (csl != 516) begin failures++; $display("FAIL loop_cs_low: got %0d want 516", csl); end
    checks++;
    if (rs != 64) begin failures++; $display("FAIL loop_sclk_rises: got %0d want 64", rs); end
    checks++;
    if (bc != 519) begin failures++; $display("FAIL loop_busy_cycles: got %0d want 519", bc); end
    checks++;
    if (mh !== 1'b0) begin failures++; $display("FAIL loop_mosi_hold: got %b want 0", mh); end
  endtask

  task automatic test_back_to_back;
    logic fc, fb, fm, mh; int csl, rs, bc, dc; logic [63:0] rx; bit fin;
    xfer(64'hA5A5A5A5A5A5A5A5, 64'h0F0F0F0F0F0F0F0F, 1'b1, 64'h5A5A5A5A5A5A5A5A,
         fc, fb, fm, csl, rs, bc, dc, rx, mh, fin);
    checks++;
    if (!fin || bc != 519 || csl != 516) begin
      failures++;
      $display("FAIL b2b_poked_timing: fin=%0d busy=%0d cs_low=%0d want 1 519 516", fin, bc, csl);
    end
    checks++;
    if (slv_in !== 64'hA5A5A5A5A5A5A5A5) begin
      failures++; $display("FAIL b2b_poked_tx: got %h want a5a5a5a5a5a5a5a5", slv_in);
    end
    checks++;
    if (rx !== 64'h0F0F0F0F0F0F0F0F || dc != 1) begin
      failures++; $display("FAIL b2b_poked_rx: got %h done=%0d want 0f0f0f0f0f0f0f0f 1", rx, dc);
    end
    // Start issued in the very first IDLE cycle
    xfer(64'h8000000000000001, 64'h123456789ABCDEF0, 1'b0, 64'h0,
         fc, fb, fm, csl, rs, bc, dc, rx, mh, fin);
    checks++;
    if (fc !== 1'b0 || fb !== 1'b1 || fm !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_idle_start: cs_n=%b busy=%b mosi=%b want 0 1 1", fc, fb, fm);
    end
    checks++;
    if (!fin || slv_in !== 64'h8000000000000001 || rx_text !== 64'h123456789ABCDEF0) begin
      failures++;
      $display("FAIL b2b_second_xfer: slave=%h rx=%h want 8000000000000001 123456789abcdef0",
               slv_in, rx_text);
    end
  endtask

  task automatic test_abort;
    logic fc, fb, fm, mh; int csl, rs, bc, dc; logic [63:0] rx; bit fin;
    logic prev_sclk; int cnt_rises; bit reached;
    slv_resp = 64'hFFFF0000FFFF0000;
    tx_text = 64'h0123456789ABCDEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_sclk = 1'b0; cnt_rises = 0; reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (sclk && !prev_sclk) cnt_rises++;
      prev_sclk = sclk;
      if (cnt_rises == 30) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL abort_reach_bit30: rises=%0d want 30", cnt_rises); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_pins: cs_n=%b sclk=%b busy=%b done=%b want 1 0 0 0", cs_n, sclk, busy, done);
    end
    checks++;
    if (rx_text !== 64'h0) begin failures++; $display("FAIL abort_rx: got %h want 0", rx_text); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_no_done: done=%b busy=%b want 0 0", done, busy);
    end
    xfer(64'hFFFFFFFFFFFFFFFF, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0,
         fc, fb, fm, csl, rs, bc, dc, rx, mh, fin);
    checks++;
    if (!fin || fm !== 1'b1 || slv_in !== 64'hFFFFFFFFFFFFFFFF) begin
      failures++;
      $display("FAIL abort_next_tx: fin=%0d mosi0=%b slave=%h want 1 1 ffffffffffffffff", fin, fm, slv_in);
    end
    checks++;
    if (rx !== 64'hDEADBEEFCAFEF00D || dc != 1) begin
      failures++; $display("FAIL abort_next_rx: got %h done=%0d want deadbeefcafef00d 1", rx, dc);
    end
    checks++;
    if (mh !== 1'b0) begin failures++; $display("FAIL abort_mosi_hold: got %b want 0", mh); end
  endtask

  task automatic test_fast_params;
    int csl, rs, dc; logic prev_sclk; bit fin; logic [63:0] rx;
    csl = 0; rs = 0; dc = 0; prev_sclk = 1'b0; fin = 1'b0; rx = '0;
    tx_f = 64'h0123456789ABCDEF;
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy_f) begin fin = 1'b1; break; end
      if (!cs_n_f) csl++;
      if (sclk_f && !prev_sclk) rs++;
      prev_sclk = sclk_f;
      if (done_f) begin dc++; rx = rx_f; end
      @(negedge clk);
    end
    checks++;
    if (!fin) begin failures++; $display("FAIL fast_timeout: busy never fell"); end
    checks++;
    if (rx !== 64'hFFFFFFFFFFFFFFFF || dc != 1) begin
      failures++; $display("FAIL fast_rx: got %h done=%0d want ffffffffffffffff 1", rx, dc);
    end
    checks++;
    if (csl != 258) begin failures++; $display("FAIL fast_cs_low: got %0d want 258", csl); end
    checks++;
    if (rs != 64) begin failures++; $display("FAIL fast_sclk_rises: got %0d want 64", rs); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_abort();
    test_fast_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
